mem_io_responder: RTL and testbench

//   Memory/IO responder for the CPU byte bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_byte_fifo.sv | 49 ++++
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the CPU byte-bus memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_UART,
    SEL_CLK0,
    SEL_CLKHI,
    SEL_NONE
  } sel_e;

  function automatic sel_e decode_addr(input logic [17:0] a);
    if (a[17:16] != IO_SEL)             return SEL_RAM;
    if (a == IO_UART_ADDR)              return SEL_UART;
    if (a == IO_CLK_ADDR)               return SEL_CLK0;
    if (a[17:2] == IO_CLK_ADDR[17:2])   return SEL_CLKHI;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: 128KB RAM, UART TX FIFO / RX port, program-stop flag.
// Define CYCLE_COUNTER_EN to include the cycle counter and its read snapshot.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W    = 17,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned FULL_MARGIN   = 4,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(TX_DEPTH - FULL_MARGIN);

  logic [17:0]           a;
  logic [RAM_ADDR_W-1:0] idx;
  sel_e                  sel;
  logic                  unused_addr_hi;

  assign a              = mem_a[17:0];
  assign idx            = mem_a[RAM_ADDR_W-1:0];
  assign sel            = decode_addr(a);
  assign unused_addr_hi = ^mem_a[31:18];

  logic [7:0] ram [2**RAM_ADDR_W];

  always_ff @(posedge clk_in) begin
    if (mem_wr && sel == SEL_RAM) ram[idx] <= mem_dout;
  end

  logic [7:0] clk0_byte, clkhi_byte;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cnt_q, snap_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (!mem_wr && sel == SEL_CLK0) snap_q <= cnt_q;
    end
  end

  // Byte 0 is live so a multi-byte read sequence starting at 0x30004 stays coherent.
  assign clk0_byte  = cnt_q[7:0];
  assign clkhi_byte = snap_q[{a[1:0], 3'b000} +: 8];
`else
  assign clk0_byte  = '0;
  assign clkhi_byte = '0;
`endif

  logic [7:0]    io_rdata;
  logic          rx_pop;
  logic          push, pop, drop, fifo_empty, fifo_full;
  logic [7:0]    push_data;
  logic [CW-1:0] fifo_count;

  always_comb begin
    io_rdata  = '0;
    rx_pop    = 1'b0;
    push      = 1'b0;
    push_data = mem_dout;
    unique case (sel)
      SEL_UART: begin
        if (!mem_wr && rx_valid) begin
          io_rdata = rx_data;
          rx_pop   = 1'b1;
        end
        push = mem_wr && (mem_dout != '0);
      end
      SEL_CLK0: begin
        io_rdata  = clk0_byte;
        push      = mem_wr;
        push_data = '0;
      end
      SEL_CLKHI: io_rdata = clkhi_byte;
      default: ;
    endcase
  end

  logic [7:0] mem_din_q, mem_din_d;
  logic       done_q, ovf_q;

  always_comb begin
    mem_din_d = mem_din_q;
    if (!mem_wr) mem_din_d = (sel == SEL_RAM) ? ram[idx] : io_rdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      if (mem_wr && sel == SEL_CLK0) done_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign pop = tx_valid & tx_ready;

  byte_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign mem_din        = mem_din_q;
  assign tx_valid       = ~fifo_empty;
  assign io_buffer_full = (fifo_count >= FULL_TH);
  assign rx_ready       = rx_pop & ~rst_in;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (vector table plus TX/RX/counter sequences).
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] cnt_m  = 0;
  logic [7:0]  txq[$];

  // Bytes leaving the FIFO: pop happens at the next posedge when valid & ready.
  always @(negedge clk) if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cnt_m = rst_in ? 32'd0 : cnt_m + 32'd1;
    #2;
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] d);
    mem_wr = wr; mem_a = addr; mem_dout = d;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 32'h0000_0000, 8'h00);
      step();
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vt [16];
  logic [7:0] exp_q [$];
  logic [31:0] snap;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0100, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vt[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[4]  = '{1'b1, 32'h0000_0000, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A};
    vt[6]  = '{1'b1, 32'h0000_0100, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hC3};
    vt[8]  = '{1'b0, 32'hFFFC_0100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hC3};
    vt[9]  = '{1'b0, 32'h0002_0000, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A};
    vt[10] = '{1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vt[11] = '{1'b1, 32'h0003_0010, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[12] = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h37, 1'b1, 8'h37};
    vt[13] = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h99, 1'b1, 8'h00};
    vt[14] = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[15] = '{1'b1, 32'h0000_0200, 8'h77, 1'b0, 8'h00, 1'b1, 8'h3C};

    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(1'b0, 32'h0, 8'h00);
    repeat (3) step();
    rst_in = 1'b0;

    chk("reset_mem_din", mem_din, 8'h00);
    chk("reset_rx_ready", rx_ready, 1'b0);
    chk("reset_program_done", program_done, 1'b0);
    chk("reset_tx_overflow", tx_overflow, 1'b0);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_io_buffer_full", io_buffer_full, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].wr, vt[i].a, vt[i].d);
      rx_valid = vt[i].rxv; rx_data = vt[i].rxd;
      step();
      if (vt[i].chk) chk($sformatf("vec%0d_mem_din", i), mem_din, vt[i].exp_din);
    end
    rx_valid = 1'b0;
    chk("table_no_tx", tx_valid, 1'b0);

    // RX pop pulse
    rx_valid = 1'b1; rx_data = 8'h37;
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1 chk("rx_ready_pulse", rx_ready, 1'b1);
    step();
    chk("rx_read_data", mem_din, 8'h37);
    drive(1'b0, 32'h0000_0100, 8'h00);
    #1 chk("rx_ready_ram_read", rx_ready, 1'b0);
    step();
    rx_valid = 1'b0;
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1 chk("rx_ready_no_valid", rx_ready, 1'b0);
    step();
    chk("rx_empty_read", mem_din, 8'h00);

    // 'H','i',0x00 streamed with tx_ready high
    tx_ready = 1'b1; txq.delete();
    drive(1'b1, 32'h0003_0000, 8'h48); step();
    drive(1'b1, 32'h0003_0000, 8'h69); step();
    drive(1'b1, 32'h0003_0000, 8'h00); step();
    idle(5);
    chk("hi_count", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("hi_byte0", txq[0], 8'h48);
      chk("hi_byte1", txq[1], 8'h69);
    end
    chk("hi_drained", tx_valid, 1'b0);

    // Fill to near-full, full, overflow, then push+pop while full
    tx_ready = 1'b0; txq.delete();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 32'h0003_0000, 8'(i)); step();
      if (i == 11) chk("nearfull_at11", io_buffer_full, 1'b0);
      if (i == 12) chk("nearfull_at12", io_buffer_full, 1'b1);
      if (i == 16) chk("no_ovf_at16", tx_overflow, 1'b0);
      if (i == 17) chk("ovf_at17", tx_overflow, 1'b1);
    end
    tx_ready = 1'b1;
    drive(1'b1, 32'h0003_0000, 8'h55); step();
    chk("full_pushpop_nearfull", io_buffer_full, 1'b1);
    idle(20);
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h55);
    chk("fill_drain_count", txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      chk($sformatf("fill_drain_byte%0d", i), txq[i], exp_q[i]);
    chk("drain_nearfull_clear", io_buffer_full, 1'b0);
    chk("ovf_sticky", tx_overflow, 1'b1);

    // Program stop: terminator queued behind pending byte
    tx_ready = 1'b0; txq.delete();
    drive(1'b1, 32'h0003_0000, 8'h41); step();
    chk("done_before", program_done, 1'b0);
    drive(1'b1, 32'h0003_0004, 8'hEE); step();
    chk("done_after", program_done, 1'b1);
    tx_ready = 1'b1;
    idle(4);
    chk("done_tx_count", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("done_tx_byte0", txq[0], 8'h41);
      chk("done_tx_term", txq[1], 8'h00);
    end

    // Reset mid-transfer: pending read discarded, FIFO flushed, flags cleared
    tx_ready = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h77); step();
    drive(1'b1, 32'h0003_0000, 8'h78); step();
    chk("pre_reset_tx_valid", tx_valid, 1'b1);
    drive(1'b0, 32'h0000_0100, 8'h00);
    rst_in = 1'b1; step();
    rst_in = 1'b0;
    chk("midrst_mem_din", mem_din, 8'h00);
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_done", program_done, 1'b0);
    chk("midrst_ovf", tx_overflow, 1'b0);
    chk("midrst_ram_kept_setup", cnt_m, 32'd0);
    drive(1'b0, 32'h0000_0100, 8'h00); step();
    chk("midrst_ram_kept", mem_din, 8'hC3);

    // Cycle counter and snapshot
    while (cnt_m < 32'd299) idle(1);
    snap = cnt_m;
    drive(1'b0, 32'h0003_0004, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte0_live", mem_din, snap[7:0]);
`else
    chk("clk_byte0_off", mem_din, 8'h00);
`endif
    idle(300);
    drive(1'b0, 32'h0003_0005, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte1_snap", mem_din, snap[15:8]);
`else
    chk("clk_byte1_off", mem_din, 8'h00);
`endif
    drive(1'b0, 32'h0003_0006, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte2_snap", mem_din, snap[23:16]);
`else
    chk("clk_byte2_off", mem_din, 8'h00);
`endif
    drive(1'b0, 32'h0003_0007, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte3_snap", mem_din, snap[31:24]);
`else
    chk("clk_byte3_off", mem_din, 8'h00);
`endif
    snap = cnt_m;
    drive(1'b0, 32'h0003_0004, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte0_relatch", mem_din, snap[7:0]);
`else
    chk("clk_byte0_relatch_off", mem_din, 8'h00);
`endif
    drive(1'b0, 32'h0003_0005, 8'h00); step();
`ifdef CYCLE_COUNTER_EN
    chk("clk_byte1_relatch", mem_din, snap[15:8]);
`else
    chk("clk_byte1_relatch_off", mem_din, 8'h00);
`endif
    drive(1'b1, 32'h0000_0300, 8'h12); step();
    chk("hold_on_write", mem_din, 8'h00 | (cnt_m == 0 ? 8'h00 : mem_din_hold_exp(snap)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic [7:0] mem_din_hold_exp(input logic [31:0] s);
`ifdef CYCLE_COUNTER_EN
    return s[15:8];
`else
    return 8'h00;
`endif
  endfunction

endmodule
